// File: rtl/pulse_sched_pkg.sv
// Shared types and helpers for the pulse_sched block.
package pulse_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // The gap counter holds GAP-1 down to 0, so it never needs to represent GAP itself.
    function automatic int gap_cnt_w(input int gap);
        return (gap <= 2) ? 1 : $clog2(gap);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr wins.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves a latch behind.
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int c;
            c = (int'(ptr) + i) % NREQ;
            if (!valid && req[c]) begin
                valid  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/pulse_sched.sv
// Shares one extended-pulse generator between NREQ requesters with round-robin arbitration.
// Optional macro PULSE_SCHED_RETRIGGER_EN: owner re-requests extend the running pulse.
module pulse_sched
    import pulse_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int CW      = 8,
    parameter int DEF_LEN = 32,
    parameter int GAP     = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NREQ-1:0]         req_i,
    input  logic                    cfg_we_i,
    input  logic [$clog2(NREQ)-1:0] cfg_ch_i,
    input  logic [CW-1:0]           cfg_len_i,
    input  logic                    ovf_clr_i,
    output logic                    o,
    output logic                    no,
    output logic [NREQ-1:0]         gnt_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [NREQ-1:0]         ovf_o
);

    localparam int IW = $clog2(NREQ);
    localparam int GW = gap_cnt_w(GAP);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic [NREQ-1:0] pend_q, pend_d;
    logic [NREQ-1:0] ovf_q, ovf_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   len_q [NREQ];
    logic            o_q, no_q;

    logic [NREQ-1:0] retrig_vec, req_eff, elig, grant_vec;
    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_valid, retrig, do_arb;
    logic [CW-1:0]   grant_len, grant_load, own_len, own_load;

`ifdef PULSE_SCHED_RETRIGGER_EN
    assign retrig_vec = (state_q == ST_PULSE) ? (req_i & gnt_q) : '0;
`else
    assign retrig_vec = '0;
`endif

    assign retrig  = |retrig_vec;
    assign req_eff = req_i & ~retrig_vec;
    assign elig    = pend_q | req_eff;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req   (elig),
        .ptr   (ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // A programmed length of zero still produces a one-cycle pulse.
    assign grant_len  = len_q[arb_idx];
    assign grant_load = (grant_len == '0) ? CW'(1) : grant_len;

    always_comb begin
        own_len = '0;
        for (int c = 0; c < NREQ; c++) begin
            if (gnt_q[c]) own_len = own_len | len_q[c];
        end
    end
    assign own_load = (own_len == '0) ? CW'(1) : own_len;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        do_arb  = 1'b0;

        case (state_q)
            ST_IDLE: do_arb = 1'b1;
            ST_PULSE: begin
                if (retrig) begin
                    cnt_d = own_load;
                end else if (cnt_q == CW'(1)) begin
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                        gcnt_d  = GW'(GAP - 1);
                        gnt_d   = '0;
                    end else begin
                        do_arb = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_GAP: begin
                if (gcnt_q == '0) do_arb = 1'b1;
                else              gcnt_d = gcnt_q - GW'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_arb) begin
            if (arb_valid) begin
                state_d = ST_PULSE;
                cnt_d   = grant_load;
                gnt_d   = arb_gnt;
                ptr_d   = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
            end else begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        end

        grant_vec = (do_arb && arb_valid) ? arb_gnt : '0;
        pend_d    = (pend_q | req_eff) & ~grant_vec;
        // A fresh overflow beats a simultaneous clear.
        ovf_d     = (ovf_clr_i ? '0 : ovf_q) | (req_eff & pend_q & ~grant_vec);
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments here so every register samples pre-edge values.
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            pend_q  <= '0;
            ovf_q   <= '0;
            gnt_q   <= '0;
            ptr_q   <= '0;
            o_q     <= 1'b0;
            no_q    <= 1'b1;
            // NOTE: the length file is reset because software relies on DEF_LEN after reset.
            for (int c = 0; c < NREQ; c++) len_q[c] <= CW'(DEF_LEN);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            o_q     <= (state_d == ST_PULSE);
            no_q    <= (state_d != ST_PULSE);
            if (cfg_we_i) len_q[cfg_ch_i] <= cfg_len_i;
        end
    end

    assign o      = o_q;
    assign no     = no_q;
    assign gnt_o  = gnt_q;
    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_PULSE) && (cnt_q == CW'(1)) && !retrig;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_pulse_sched.sv
// Directed self-checking bench for pulse_sched (GAP=2 instance plus a GAP=0 instance).
module tb_pulse_sched;

    localparam int NREQ = 4;
    localparam int CW   = 8;
`ifdef PULSE_SCHED_RETRIGGER_EN
    localparam int G0_HOLD = 1;
`else
    localparam int G0_HOLD = 4;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, cfg_we, ovf_clr;
    logic [NREQ-1:0] req;
    logic [1:0]      cfg_ch;
    logic [CW-1:0]   cfg_len;
    logic            o, no, busy, done;
    logic [NREQ-1:0] gnt, ovf;

    logic            g_rst, g_cfg_we, g_ovf_clr;
    logic [NREQ-1:0] g_req;
    logic [1:0]      g_cfg_ch;
    logic [CW-1:0]   g_cfg_len;
    logic            g_o, g_no, g_busy, g_done;
    logic [NREQ-1:0] g_gnt, g_ovf;

    int checks = 0;
    int errors = 0;

    pulse_sched #(.NREQ(NREQ), .CW(CW), .DEF_LEN(32), .GAP(2)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch),
        .cfg_len_i(cfg_len), .ovf_clr_i(ovf_clr), .o(o), .no(no), .gnt_o(gnt),
        .busy_o(busy), .done_o(done), .ovf_o(ovf)
    );

    pulse_sched #(.NREQ(NREQ), .CW(CW), .DEF_LEN(32), .GAP(0)) u_g0 (
        .clk_i(clk), .rst_i(g_rst), .req_i(g_req), .cfg_we_i(g_cfg_we), .cfg_ch_i(g_cfg_ch),
        .cfg_len_i(g_cfg_len), .ovf_clr_i(g_ovf_clr), .o(g_o), .no(g_no), .gnt_o(g_gnt),
        .busy_o(g_busy), .done_o(g_done), .ovf_o(g_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int ch, input int len);
        cfg_we  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_len = CW'(len);
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic gcfg(input int ch, input int len);
        g_cfg_we  = 1'b1;
        g_cfg_ch  = 2'(ch);
        g_cfg_len = CW'(len);
        tick();
        g_cfg_we  = 1'b0;
    endtask

    task automatic main_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int hi, dn;
        logic saw;
        rst = 1'b1; cfg_we = 1'b0; ovf_clr = 1'b0; req = '0; cfg_ch = '0; cfg_len = '0;
        g_rst = 1'b1; g_cfg_we = 1'b0; g_ovf_clr = 1'b0; g_req = '0; g_cfg_ch = '0; g_cfg_len = '0;
        repeat (3) tick();
        rst = 1'b0; g_rst = 1'b0;

        // Reset state
        check("rst_o", o, 0);
        check("rst_no", no, 1);
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);

        // Single ch1 pulse of length 5 followed by two gap cycles
        cfg(1, 5);
        req = 4'b0010;
        tick();
        req = '0;
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("p1_o_c%0d", i), o, 1);
            check($sformatf("p1_no_c%0d", i), no, 0);
            check($sformatf("p1_gnt_c%0d", i), gnt, 4'b0010);
            check($sformatf("p1_done_c%0d", i), done, (i == 5));
            tick();
        end
        for (int g = 1; g <= 2; g++) begin
            check($sformatf("p1_gap_o%0d", g), o, 0);
            check($sformatf("p1_gap_busy%0d", g), busy, 1);
            check($sformatf("p1_gap_gnt%0d", g), gnt, 0);
            tick();
        end
        check("p1_idle_busy", busy, 0);
        check("p1_idle_o", o, 0);

        // All four request together: round-robin from channel 0, length 3 each
        main_reset();
        for (int c = 0; c < NREQ; c++) cfg(c, 3);
        req = 4'b1111;
        tick();
        req = '0;
        for (int c = 0; c < NREQ; c++) begin
            for (int i = 1; i <= 3; i++) begin
                check($sformatf("rr_ch%0d_o_c%0d", c, i), o, 1);
                check($sformatf("rr_ch%0d_gnt_c%0d", c, i), gnt, 32'(1) << c);
                check($sformatf("rr_ch%0d_done_c%0d", c, i), done, (i == 3));
                tick();
            end
            for (int g = 1; g <= 2; g++) begin
                check($sformatf("rr_ch%0d_gap_o%0d", c, g), o, 0);
                check($sformatf("rr_ch%0d_gap_gnt%0d", c, g), gnt, 0);
                tick();
            end
        end
        check("rr_idle_busy", busy, 0);

`ifndef PULSE_SCHED_RETRIGGER_EN
        // Two re-requests from ch2 during its own pulse: one queued, one overflow
        req = 4'b0100;
        tick();
        check("ov_first_gnt", gnt, 4'b0100);
        tick();
        check("ov_pend_no_ovf", ovf, 0);
        tick();
        req = '0;
        check("ov_set", ovf, 4'b0100);
        check("ov_first_done", done, 1);
        repeat (3) tick();
        check("ov_second_o", o, 1);
        check("ov_second_gnt", gnt, 4'b0100);
        repeat (2) tick();
        check("ov_second_done", done, 1);
        repeat (3) tick();
        check("ov_no_third_busy", busy, 0);
        check("ov_no_third_o", o, 0);
        check("ov_sticky", ovf, 4'b0100);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ov_cleared", ovf, 0);
`endif

        // GAP=0 instance, zero lengths: back-to-back 1-cycle pulses alternating ch0/ch1
        gcfg(0, 0);
        gcfg(1, 0);
        g_req = 4'b0011;
        for (int k = 0; k <= G0_HOLD; k++) begin
            if (k == G0_HOLD) g_req = '0;
            tick();
            check($sformatf("g0_o_%0d", k), g_o, 1);
            check($sformatf("g0_gnt_%0d", k), g_gnt, (k % 2 == 0) ? 4'b0001 : 4'b0010);
            check($sformatf("g0_done_%0d", k), g_done, 1);
        end
        tick();
        check("g0_idle_o", g_o, 0);
        check("g0_idle_busy", g_busy, 0);
        check("g0_ovf", g_ovf, 0);

        // Reset during cycle 3 of an 8-cycle ch0 pulse with ch3 pending
        cfg(0, 8);
        req = 4'b0001;
        tick();
        check("rs_gnt", gnt, 4'b0001);
        req = 4'b1000;
        tick();
        req = '0;
        tick();
        check("rs_c3_o", o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rs_o", o, 0);
        check("rs_no", no, 1);
        check("rs_gnt0", gnt, 0);
        check("rs_busy", busy, 0);
        saw = 1'b0;
        repeat (15) begin
            tick();
            if (o) saw = 1'b1;
        end
        check("rs_no_ch3_pulse", saw, 0);

        // Length registers are back at DEF_LEN after reset
        req = 4'b0001;
        tick();
        req = '0;
        hi = 0;
        repeat (40) begin
            if (o) hi++;
            tick();
        end
        check("rs_def_len", hi, 32);

`ifdef PULSE_SCHED_RETRIGGER_EN
        // Owner re-request on cycle 3 of a 4-cycle pulse extends it to 7 cycles
        cfg(0, 4);
        req = 4'b0001;
        tick();
        hi = 0;
        dn = 0;
        for (int i = 0; i < 16; i++) begin
            if (o) hi++;
            if (done) dn++;
            req = (i == 2) ? 4'b0001 : 4'b0000;
            tick();
        end
        req = '0;
        check("rt_high_cycles", hi, 7);
        check("rt_done_count", dn, 1);
        check("rt_no_ovf", ovf, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
